// File: rtl/pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_ctrl
// Description : PLL reset sequencer. Pulses the PLL reset, waits for a
//               synchronized and stable lock indication, then releases the
//               downstream reset. Retries on lock timeout and gives up after
//               MAX_RETRIES timeouts. Counts lock-loss events seen while
//               running.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_ctrl #(
  parameter int RST_CYCLES         = 16,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int MAX_RETRIES        = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  // cnt serves both the reset-pulse length and the stability run, so it is
  // sized for whichever is larger; tmo must be able to hold LOCK_TIMEOUT.
  localparam int c_CNT_MAX = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES
                                                                : LOCK_STABLE_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_TMO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_RST_LAST  = c_CNT_W'(RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE    = c_CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [c_TMO_W-1:0] c_TMO_ZERO  = '0;
  localparam logic [c_TMO_W-1:0] c_TMO_ONE   = c_TMO_W'(1);
  localparam logic [c_TMO_W-1:0] c_TMO_LIMIT = c_TMO_W'(LOCK_TIMEOUT);
  localparam logic [3:0]         c_MAX_RETRY = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_TMO_W-1:0] r_tmo;
  logic [3:0]         r_retry;
  logic [7:0]         r_loss;
  logic               r_pll_rst;
  logic               r_sys_rst;
  logic               r_fail;
  logic               r_lock_lost;

  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_TMO_W-1:0] w_tmo_nxt;
  logic [c_TMO_W-1:0] w_tmo_inc;
  logic               w_timeout;
  logic [3:0]         w_retry_inc;
  logic [3:0]         w_retry_nxt;
  logic [7:0]         w_loss_nxt;
  logic               w_lost_nxt;
  logic               w_locked_s;

  assign w_locked_s  = r_sync2;
  assign w_tmo_inc   = r_tmo + c_TMO_ONE;
  assign w_timeout   = (w_tmo_inc == c_TMO_LIMIT);
  assign w_retry_inc = r_retry + 4'd1;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counter and event logic of the sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    w_lost_nxt  = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == c_RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = c_CNT_ZERO;
          w_tmo_nxt   = c_TMO_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      S_WAIT_LOCK, S_STABLE: begin
        w_tmo_nxt = w_tmo_inc;
        if (w_timeout) begin
          // Timeout outranks any lock transition in the same cycle.
          w_retry_nxt = w_retry_inc;
          w_cnt_nxt   = c_CNT_ZERO;
          w_state_nxt = (w_retry_inc == c_MAX_RETRY) ? S_FAIL : S_RESET_PLL;
        end else if (r_state == S_WAIT_LOCK) begin
          if (w_locked_s) begin
            w_state_nxt = S_STABLE;
            w_cnt_nxt   = c_CNT_ONE;
          end
        end else if (!w_locked_s) begin
          // Any dropout restarts the stability run; tmo keeps running.
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = c_CNT_ZERO;
        end else if (r_cnt == c_STABLE) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      S_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = c_CNT_ZERO;
          w_lost_nxt  = 1'b1;
          if (r_loss != 8'hFF) begin
            w_loss_nxt = r_loss + 8'd1;
          end
        end
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        w_state_nxt = S_RESET_PLL;
        w_cnt_nxt   = c_CNT_ZERO;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state and come straight from flops.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= c_CNT_ZERO;
      r_tmo       <= c_TMO_ZERO;
      r_retry     <= 4'd0;
      r_loss      <= 8'd0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_fail      <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_retry     <= w_retry_nxt;
      r_loss      <= w_loss_nxt;
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAIL);
      r_sys_rst   <= (w_state_nxt != S_RUN);
      r_fail      <= (w_state_nxt == S_FAIL);
      r_lock_lost <= w_lost_nxt;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst   = r_sys_rst;
  assign fail      = r_fail;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;

endmodule
`default_nettype wire
